// File: rtl/cpu_control_fsm_if.sv
// cpu_control_fsm_if: instruction/data memory handshake bundle between the
// control FSM (master) and the memory system (slave).
interface cpu_control_fsm_if #(
    parameter int PC_WIDTH = 8
);
    logic [PC_WIDTH-1:0] imem_addr;
    logic [15:0]         imem_rdata;
    logic                imem_req;
    logic                imem_ack;
    logic                dmem_req;
    logic                dmem_ack;
    logic                dmem_we;

    modport master (
        output imem_addr, imem_req, dmem_req, dmem_we,
        input  imem_rdata, imem_ack, dmem_ack
    );

    modport slave (
        input  imem_addr, imem_req, dmem_req, dmem_we,
        output imem_rdata, imem_ack, dmem_ack
    );
endinterface

// File: rtl/cpu_control_fsm.sv
// cpu_control_fsm: multi-cycle fetch/decode/execute/memory/writeback sequencer
// owning pc, ir, Z/N/V flags and the retired-instruction counter.
module cpu_control_fsm #(
    parameter int PC_WIDTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    cpu_control_fsm_if.master bus,
    input  logic [3:0]        opcode,
    input  logic              cc_success,
    input  logic              alu_zero,
    input  logic              alu_neg,
    input  logic              alu_ovf,
    output logic [15:0]       ir,
    output logic              zero,
    output logic              neg,
    output logic              ovf,
    output logic              alu_en,
    output logic              reg_we,
    output logic              halted,
    output logic [2:0]        state,
    output logic [15:0]       retired
);
    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam logic [3:0] OP_NOP    = 4'b0000;
    localparam logic [3:0] OP_HALT   = 4'b1100;
    localparam logic [3:0] OP_LOAD   = 4'b1101;
    localparam logic [3:0] OP_STORE  = 4'b1110;
    localparam logic [3:0] OP_BRANCH = 4'b1111;

    logic [2:0]          state_d, state_q;
    logic [PC_WIDTH-1:0] pc_d, pc_q;
    logic [15:0]         ir_d, ir_q;
    logic [15:0]         retired_d, retired_q;
    logic [2:0]          flags_d, flags_q;
    logic                imem_req_d, imem_req_q;
    logic                retire, branch;

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        flags_d = flags_q;
        retire  = 1'b0;
        branch  = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (imem_req_q && bus.imem_ack) begin
                    ir_d    = bus.imem_rdata;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                retire  = !cc_success || opcode == OP_NOP || opcode == OP_HALT || opcode == OP_BRANCH;
                branch  = cc_success && opcode == OP_BRANCH;
                state_d = !retire ? S_EXEC : (cc_success && opcode == OP_HALT) ? S_HALT : S_FETCH;
            end
            S_EXEC: begin
                // Memory ops keep the flags; everything else reaching EXEC is an ALU op.
                state_d = (opcode == OP_LOAD || opcode == OP_STORE) ? S_MEM : S_WB;
                flags_d = (state_d == S_WB) ? {alu_zero, alu_neg, alu_ovf} : flags_q;
            end
            S_MEM: begin
                if (bus.dmem_ack) begin
                    retire  = opcode == OP_STORE;
                    state_d = retire ? S_FETCH : S_WB;
                end
            end
            S_WB: begin
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
        pc_d       = branch ? pc_q + PC_WIDTH'($signed(ir_q[6:0])) : retire ? pc_q + 1'b1 : pc_q;
        retired_d  = retire ? retired_q + 16'd1 : retired_q;
        imem_req_d = state_d == S_FETCH;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_FETCH;
            pc_q       <= '0;
            ir_q       <= '0;
            flags_q    <= '0;
            retired_q  <= '0;
            imem_req_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            flags_q    <= flags_d;
            retired_q  <= retired_d;
            imem_req_q <= imem_req_d;
        end
    end

    assign bus.imem_addr  = pc_q;
    assign bus.imem_req   = imem_req_q;
    assign bus.dmem_req   = state_q == S_MEM;
    assign bus.dmem_we    = state_q == S_MEM && opcode == OP_STORE;
    assign alu_en         = state_q == S_EXEC;
    assign reg_we         = state_q == S_WB;
    assign halted         = state_q == S_HALT;
    assign state          = state_q;
    assign ir             = ir_q;
    assign {zero, neg, ovf} = flags_q;
    assign retired        = retired_q;
endmodule

// File: tb/tb_cpu_control_fsm.sv
// tb_cpu_control_fsm: table-driven instruction runs with a scoreboard queue,
// plus hand-written HALT and reset-in-MEM sequences.
module tb_cpu_control_fsm;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  opcode;
    logic        cc_success = 1'b0;
    logic        alu_zero = 1'b0, alu_neg = 1'b0, alu_ovf = 1'b0;
    logic [15:0] ir, retired;
    logic        zero, neg, ovf, alu_en, reg_we, halted;
    logic [2:0]  state;
    int          total = 0;
    int          bad = 0;

    typedef struct {
        logic [15:0] instr;
        logic        cc;
        logic [2:0]  aflags;
        int          iw;
        int          dw;
        int          cyc;
        logic [31:0] path;
        logic [7:0]  pc;
        logic [15:0] ret;
        logic [2:0]  flags;
        int          alu;
        int          rwe;
        int          dreq;
        logic        we;
    } vec_t;

    vec_t tbl[16];
    vec_t sb[$];

    cpu_control_fsm_if #(.PC_WIDTH(8)) bus ();

    cpu_control_fsm #(.PC_WIDTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .opcode     (opcode),
        .cc_success (cc_success),
        .alu_zero   (alu_zero),
        .alu_neg    (alu_neg),
        .alu_ovf    (alu_ovf),
        .ir         (ir),
        .zero       (zero),
        .neg        (neg),
        .ovf        (ovf),
        .alu_en     (alu_en),
        .reg_we     (reg_we),
        .halted     (halted),
        .state      (state),
        .retired    (retired)
    );

    // Minimal decoder model: opcode field of the instruction register.
    assign opcode = ir[13:10];

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run(input vec_t v);
        vec_t        e;
        int          cyc = 0, w = 0, dw = 0, alu = 0, rwe = 0, dreq = 0;
        logic        we = 1'b0, both = 1'b0, left = 1'b0;
        logic [31:0] path = '0;
        sb.push_back(v);
        bus.imem_rdata = v.instr;
        cc_success = v.cc;
        {alu_zero, alu_neg, alu_ovf} = v.aflags;
        do begin
            cyc++;
            path = {path[27:0], 1'b0, state};
            left |= state != 3'd0;
            alu += int'(alu_en);
            rwe += int'(reg_we);
            if (bus.dmem_req) begin
                dreq++;
                we |= bus.dmem_we;
            end
            both |= bus.imem_req && bus.dmem_req;
            bus.imem_ack = bus.imem_req && w == v.iw;
            if (bus.imem_req) w++;
            bus.dmem_ack = bus.dmem_req && dw == v.dw;
            if (bus.dmem_req) dw++;
            tick();
            bus.imem_ack = 1'b0;
            bus.dmem_ack = 1'b0;
        end while (!(left && state == 3'd0) && state != 3'd5 && cyc < 40);
        e = sb.pop_front();
        chk($sformatf("cycles[%h]", e.instr), cyc, e.cyc);
        chk($sformatf("path[%h]", e.instr), path, e.path);
        chk($sformatf("pc[%h]", e.instr), {24'd0, bus.imem_addr}, {24'd0, e.pc});
        chk($sformatf("retired[%h]", e.instr), {16'd0, retired}, {16'd0, e.ret});
        chk($sformatf("flags[%h]", e.instr), {29'd0, zero, neg, ovf}, {29'd0, e.flags});
        chk($sformatf("alu_en[%h]", e.instr), alu, e.alu);
        chk($sformatf("reg_we[%h]", e.instr), rwe, e.rwe);
        chk($sformatf("dmem_req[%h]", e.instr), dreq, e.dreq);
        chk($sformatf("dmem_we[%h]", e.instr), {31'd0, we}, {31'd0, e.we});
        chk($sformatf("req_overlap[%h]", e.instr), {31'd0, both}, 32'd0);
        chk($sformatf("end_state[%h]", e.instr), {29'd0, state},
            (e.instr[13:10] == 4'b1100 && e.cc) ? 32'd5 : 32'd0);
    endtask

    initial begin
        bus.imem_rdata = '0;
        bus.imem_ack   = 1'b0;
        bus.dmem_ack   = 1'b0;
        //          instr     cc aflags iw dw cyc path          pc     ret    flags  alu rwe dreq we
        tbl[0]  = '{16'h0400, 1, 3'b100, 0, 0, 4, 32'h0124,     8'h01, 16'd1,  3'b100, 1, 1, 0, 0};
        tbl[1]  = '{16'h4400, 0, 3'b011, 0, 0, 2, 32'h01,       8'h02, 16'd2,  3'b100, 0, 0, 0, 0};
        tbl[2]  = '{16'h0000, 1, 3'b011, 0, 0, 2, 32'h01,       8'h03, 16'd3,  3'b100, 0, 0, 0, 0};
        tbl[3]  = '{16'h0800, 1, 3'b010, 2, 0, 6, 32'h0124,     8'h04, 16'd4,  3'b010, 1, 1, 0, 0};
        tbl[4]  = '{16'h3400, 1, 3'b111, 0, 3, 8, 32'h01233334, 8'h05, 16'd5,  3'b010, 1, 1, 4, 0};
        tbl[5]  = '{16'h3800, 1, 3'b111, 0, 0, 4, 32'h0123,     8'h06, 16'd6,  3'b010, 1, 0, 1, 1};
        tbl[6]  = '{16'h3C7C, 1, 3'b000, 0, 0, 2, 32'h01,       8'h02, 16'd7,  3'b010, 0, 0, 0, 0};
        tbl[7]  = '{16'h3C7C, 1, 3'b000, 0, 0, 2, 32'h01,       8'hFE, 16'd8,  3'b010, 0, 0, 0, 0};
        tbl[8]  = '{16'h3C03, 1, 3'b000, 0, 0, 2, 32'h01,       8'h01, 16'd9,  3'b010, 0, 0, 0, 0};
        tbl[9]  = '{16'h7C7C, 0, 3'b000, 0, 0, 2, 32'h01,       8'h02, 16'd10, 3'b010, 0, 0, 0, 0};
        tbl[10] = '{16'h3C40, 1, 3'b000, 0, 0, 2, 32'h01,       8'hC2, 16'd11, 3'b010, 0, 0, 0, 0};
        tbl[11] = '{16'h3C3F, 1, 3'b000, 0, 0, 2, 32'h01,       8'h01, 16'd12, 3'b010, 0, 0, 0, 0};
        tbl[12] = '{16'h0C00, 1, 3'b001, 1, 0, 5, 32'h0124,     8'h02, 16'd13, 3'b001, 1, 1, 0, 0};
        tbl[13] = '{16'h3400, 1, 3'b110, 0, 0, 5, 32'h01234,    8'h03, 16'd14, 3'b001, 1, 1, 1, 0};
        tbl[14] = '{16'h3800, 1, 3'b000, 0, 2, 6, 32'h012333,   8'h04, 16'd15, 3'b001, 1, 0, 3, 1};
        tbl[15] = '{16'h3000, 1, 3'b111, 0, 0, 2, 32'h01,       8'h05, 16'd16, 3'b001, 0, 0, 0, 0};

        reset = 1'b1;
        tick();
        tick();
        chk("reset_state", {29'd0, state}, 32'd0);
        chk("reset_regs", {bus.imem_addr, ir, zero, neg, ovf, halted}, 32'd0);
        chk("reset_retired", {16'd0, retired}, 32'd0);
        chk("reset_strobes", {28'd0, bus.imem_req, bus.dmem_req, alu_en, reg_we}, 32'd0);
        reset = 1'b0;
        tick();
        chk("first_imem_req", {28'd0, state, bus.imem_req}, 32'd1);

        for (int i = 0; i < 16; i++) run(tbl[i]);

        for (int i = 0; i < 6; i++) begin
            bus.imem_ack = i[0];
            bus.dmem_ack = !i[0];
            tick();
            chk($sformatf("halt_hold%0d", i),
                {15'd0, state, halted, bus.imem_addr, alu_en, reg_we, bus.imem_req, bus.dmem_req, bus.dmem_we},
                {15'd0, 3'd5, 1'b1, 8'h05, 5'b00000});
        end
        chk("halt_retired", {16'd0, retired}, 32'd16);

        bus.imem_ack = 1'b0;
        bus.dmem_ack = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        chk("post_halt_reset", {3'd0, state, halted, bus.imem_addr, retired, bus.imem_req},
            {3'd0, 3'd0, 1'b0, 8'd0, 16'd0, 1'b1});

        bus.imem_rdata = 16'h3800;
        cc_success = 1'b1;
        bus.imem_ack = 1'b1;
        tick();
        bus.imem_ack = 1'b0;
        tick();
        tick();
        chk("store_in_mem", {26'd0, state, bus.dmem_req, bus.dmem_we, reg_we}, {26'd0, 3'd3, 3'b110});
        reset = 1'b1;
        bus.dmem_ack = 1'b1;
        tick();
        reset = 1'b0;
        bus.dmem_ack = 1'b0;
        chk("reset_in_mem", {3'd0, state, bus.imem_addr, retired, bus.dmem_req, reg_we}, 32'd0);
        tick();
        chk("after_reset_mem", {27'd0, state, bus.dmem_req, bus.imem_req}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
